// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: two-way intersection phase sequencer with a per-phase tick counter.
// Define PED_REQ_EN to add the pedestrian request that can shorten a green (ped_req/ped_ack).
module traffic_phase_timer #(
  parameter int unsigned NBITS     = 16,
  parameter int unsigned GREEN_T   = 30,
  parameter int unsigned YELLOW_T  = 4,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned PED_MIN_T = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             hold,
`ifdef PED_REQ_EN
  input  logic             ped_req,
  output logic             ped_ack,
`endif
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic [2:0]       phase,
  output logic [NBITS-1:0] count,
  output logic             phase_done
);

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR1  = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR2  = 3'd5
  } phase_e;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // Durations are truncated to NBITS first, then a zero duration is clamped to one tick.
  localparam logic [NBITS-1:0] G_RAW  = NBITS'(GREEN_T);
  localparam logic [NBITS-1:0] Y_RAW  = NBITS'(YELLOW_T);
  localparam logic [NBITS-1:0] A_RAW  = NBITS'(ALLRED_T);
  localparam logic [NBITS-1:0] G_LAST = (G_RAW == '0) ? '0 : G_RAW - NBITS'(1);
  localparam logic [NBITS-1:0] Y_LAST = (Y_RAW == '0) ? '0 : Y_RAW - NBITS'(1);
  localparam logic [NBITS-1:0] A_LAST = (A_RAW == '0) ? '0 : A_RAW - NBITS'(1);

  if ($clog2(PED_MIN_T + 1) > NBITS) begin : g_ped_min_range
    $error("PED_MIN_T does not fit in NBITS");
  end

  phase_e           r_state, w_state_n, w_succ;
  logic [NBITS-1:0] r_count, w_count_n, w_last;
  logic [2:0]       r_ns, r_ew, w_ns_n, w_ew_n;
  logic             r_done, w_done_n;
  logic             w_legal, w_step, w_match, w_cut, w_adv;

  always_comb begin
    w_last  = A_LAST;
    w_succ  = AR2;
    w_legal = 1'b1;
    case (r_state)
      NS_G: begin w_last = G_LAST; w_succ = NS_Y; end
      NS_Y: begin w_last = Y_LAST; w_succ = AR1;  end
      AR1:  begin w_last = A_LAST; w_succ = EW_G; end
      EW_G: begin w_last = G_LAST; w_succ = EW_Y; end
      EW_Y: begin w_last = Y_LAST; w_succ = AR2;  end
      AR2:  begin w_last = A_LAST; w_succ = NS_G; end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_step  = tick & ~hold;
  assign w_match = ~|(r_count ^ w_last);
  assign w_adv   = w_step & (w_match | w_cut);

`ifdef PED_REQ_EN
  localparam logic [NBITS-1:0] P_THR = (PED_MIN_T == 0) ? '0 : NBITS'(PED_MIN_T - 1);

  logic r_ped_flag, r_ped_ack;

  assign w_cut = r_ped_flag & ((r_state == NS_G) | (r_state == EW_G)) & (r_count >= P_THR);

  // The clear on a cut wins over a request seen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ped_flag <= 1'b0;
      r_ped_ack  <= 1'b0;
    end else begin
      r_ped_ack <= w_step & w_cut;
      if (w_step & w_cut)
        r_ped_flag <= 1'b0;
      else if (ped_req)
        r_ped_flag <= 1'b1;
    end
  end

  assign ped_ack = r_ped_ack;
`else
  assign w_cut = 1'b0;
`endif

  always_comb begin
    w_state_n = r_state;
    w_count_n = r_count;
    w_done_n  = 1'b0;
    if (!w_legal) begin
      w_state_n = AR2;
      w_count_n = '0;
    end else if (w_adv) begin
      w_state_n = w_succ;
      w_count_n = '0;
      w_done_n  = 1'b1;
    end else if (w_step) begin
      w_count_n = r_count + NBITS'(1);
    end
  end

  always_comb begin
    w_ns_n = LAMP_R;
    w_ew_n = LAMP_R;
    case (w_state_n)
      NS_G:    w_ns_n = LAMP_G;
      NS_Y:    w_ns_n = LAMP_Y;
      EW_G:    w_ew_n = LAMP_G;
      EW_Y:    w_ew_n = LAMP_Y;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= AR2;
      r_count <= '0;
      r_ns    <= LAMP_R;
      r_ew    <= LAMP_R;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_count <= w_count_n;
      r_ns    <= w_ns_n;
      r_ew    <= w_ew_n;
      r_done  <= w_done_n;
    end
  end

  assign phase      = r_state;
  assign count      = r_count;
  assign ns_light   = r_ns;
  assign ew_light   = r_ew;
  assign phase_done = r_done;

endmodule
